// File: rtl/audio_buffer_writer.sv
// Ping-pong audio buffer writer: on a codec request, acknowledges with a four-phase
// handshake, then streams 2^BUFFER_ADDR_BITS samples into the inactive RAM half.
module audio_buffer_writer #(
  parameter int BUFFER_ADDR_BITS = 9,
  parameter int DATA_BITS        = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_BITS-1:0]        src_data_i,
  input  logic                        src_valid_i,
  output logic                        src_ready_o,
  input  logic                        buffer_sel_i,
  input  logic                        buffer_empty_i,
  output logic                        buffer_empty_ack_o,
  output logic                        buffer_filled_o,
  output logic                        ram_wren_o,
  output logic [BUFFER_ADDR_BITS:0]   ram_wr_addr_o,
  output logic [DATA_BITS-1:0]        ram_wr_data_o,
  output logic                        underrun_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    FILL = 2'd2
  } state_t;

  state_t                      state_q, state_d;
  logic                        half_q, half_d;
  logic [BUFFER_ADDR_BITS-1:0] addr_q, addr_d;
  logic                        filled_q, filled_d;
  logic                        underrun_q, underrun_d;
  logic                        wren_q, wren_d;
  logic [BUFFER_ADDR_BITS:0]   wr_addr_q, wr_addr_d;
  logic [DATA_BITS-1:0]        wr_data_q, wr_data_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      half_q     <= 1'b0;
      addr_q     <= '0;
      filled_q   <= 1'b0;
      underrun_q <= 1'b0;
      wren_q     <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      half_q     <= half_d;
      addr_q     <= addr_d;
      filled_q   <= filled_d;
      underrun_q <= underrun_d;
      wren_q     <= wren_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    half_d     = half_q;
    addr_d     = addr_q;
    filled_d   = filled_q;
    underrun_d = underrun_q;
    wren_d     = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    case (state_q)
      IDLE: begin
        if (buffer_empty_i) begin
          state_d  = ACK;
          half_d   = ~buffer_sel_i;
          filled_d = 1'b0;
        end
      end
      ACK: begin
        if (!buffer_empty_i) begin
          state_d = FILL;
          addr_d  = '0;
        end
      end
      FILL: begin
        // A request arriving mid-fill is flagged but left pending until IDLE.
        if (buffer_empty_i) underrun_d = 1'b1;
        if (src_valid_i) begin
          wren_d    = 1'b1;
          wr_addr_d = {half_q, addr_q};
          wr_data_d = src_data_i;
          if (&addr_q) begin
            state_d  = IDLE;
            filled_d = 1'b1;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign src_ready_o        = (state_q == FILL);
  assign buffer_empty_ack_o = (state_q == ACK);
  assign buffer_filled_o    = filled_q;
  assign ram_wren_o         = wren_q;
  assign ram_wr_addr_o      = wr_addr_q;
  assign ram_wr_data_o      = wr_data_q;
  assign underrun_o         = underrun_q;

endmodule

// File: tb/tb_audio_buffer_writer.sv
// Bench for audio_buffer_writer with 8-sample halves: vector table, corner sequences
// and a random run, all checked against a transaction-level model of a fill.
module tb_audio_buffer_writer;
  localparam int AB = 3;
  localparam int DB = 8;
  localparam int HALF_LEN = 1 << AB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DB-1:0] src_data_i = '0;
  logic          src_valid_i = 1'b0;
  logic          src_ready_o;
  logic          buffer_sel_i = 1'b0;
  logic          buffer_empty_i = 1'b0;
  logic          buffer_empty_ack_o;
  logic          buffer_filled_o;
  logic          ram_wren_o;
  logic [AB:0]   ram_wr_addr_o;
  logic [DB-1:0] ram_wr_data_o;
  logic          underrun_o;

  audio_buffer_writer #(.BUFFER_ADDR_BITS(AB), .DATA_BITS(DB)) dut (
    .clk(clk), .rst(rst),
    .src_data_i(src_data_i), .src_valid_i(src_valid_i), .src_ready_o(src_ready_o),
    .buffer_sel_i(buffer_sel_i), .buffer_empty_i(buffer_empty_i),
    .buffer_empty_ack_o(buffer_empty_ack_o), .buffer_filled_o(buffer_filled_o),
    .ram_wren_o(ram_wren_o), .ram_wr_addr_o(ram_wr_addr_o),
    .ram_wr_data_o(ram_wr_data_o), .underrun_o(underrun_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a request is either waiting, being handshaken, or being filled with
  // a known number of samples already stored.
  bit waiting_req_release, filling, hs;
  int m_cnt, m_half, m_filled, m_under, m_wren, m_wa, m_wd;

  function automatic void model_reset();
    filling = 0; hs = 0; m_cnt = 0; m_half = 0; m_filled = 0;
    m_under = 0; m_wren = 0; m_wa = 0; m_wd = 0;
  endfunction

  function automatic void model_edge();
    m_wren = 0;
    if (filling) begin
      if (buffer_empty_i) m_under = 1;
      if (src_valid_i) begin
        m_wren = 1;
        m_wa   = m_half * HALF_LEN + m_cnt;
        m_wd   = int'(src_data_i);
        m_cnt  = m_cnt + 1;
        if (m_cnt == HALF_LEN) begin
          filling  = 0;
          m_filled = 1;
        end
      end
    end else if (hs) begin
      if (!buffer_empty_i) begin
        hs = 0; filling = 1; m_cnt = 0;
      end
    end else if (buffer_empty_i) begin
      hs = 1; m_half = buffer_sel_i ? 0 : 1; m_filled = 0;
    end
  endfunction

  task automatic compare_all(input string tag);
    chk({tag, "_ready"},  int'(src_ready_o),        int'(filling));
    chk({tag, "_ack"},    int'(buffer_empty_ack_o), int'(hs));
    chk({tag, "_filled"}, int'(buffer_filled_o),    m_filled);
    chk({tag, "_wren"},   int'(ram_wren_o),         m_wren);
    chk({tag, "_waddr"},  int'(ram_wr_addr_o),      m_wa);
    chk({tag, "_wdata"},  int'(ram_wr_data_o),      m_wd);
    chk({tag, "_under"},  int'(underrun_o),         m_under);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    compare_all(tag);
  endtask

  typedef struct {
    logic          empty, sel, valid;
    logic [DB-1:0] data;
    logic          e_ack, e_rdy, e_wren;
    logic [AB:0]   e_addr;
    logic [DB-1:0] e_data;
    logic          e_filled;
  } vec_t;

  vec_t vt[11];
  int   wr_addrs[$];

  initial begin
    // basic fill, sel=0 so the latched half is 1 (addresses 8..15)
    vt[0] = '{1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0};
    vt[1] = '{1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 4'd0, 8'd0, 1'b0};
    for (int k = 1; k <= 8; k++)
      vt[k+1] = '{1'b0, 1'b0, 1'b1, DB'(k), 1'b0, (k < 8), 1'b1, 4'(7 + k), DB'(k), (k == 8)};
    vt[10] = '{1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 4'd15, 8'd8, 1'b1};

    model_reset();
    #12;
    compare_all("reset");
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      buffer_empty_i = vt[i].empty;
      buffer_sel_i   = vt[i].sel;
      src_valid_i    = vt[i].valid;
      src_data_i     = vt[i].data;
      step("vec");
      chk($sformatf("vec%0d_ack", i),    int'(buffer_empty_ack_o), int'(vt[i].e_ack));
      chk($sformatf("vec%0d_rdy", i),    int'(src_ready_o),        int'(vt[i].e_rdy));
      chk($sformatf("vec%0d_wren", i),   int'(ram_wren_o),         int'(vt[i].e_wren));
      chk($sformatf("vec%0d_addr", i),   int'(ram_wr_addr_o),      int'(vt[i].e_addr));
      chk($sformatf("vec%0d_data", i),   int'(ram_wr_data_o),      int'(vt[i].e_data));
      chk($sformatf("vec%0d_filled", i), int'(buffer_filled_o),    int'(vt[i].e_filled));
    end

    // handshake: request held 5 cycles, then released
    buffer_empty_i = 1'b1; buffer_sel_i = 1'b0; src_valid_i = 1'b1; src_data_i = 8'h55;
    for (int i = 0; i < 5; i++) begin
      step("hs");
      chk("hs_ack_high", int'(buffer_empty_ack_o), 1);
      chk("hs_no_write", int'(ram_wren_o), 0);
      if (i == 0) chk("hs_filled_drop", int'(buffer_filled_o), 0);
    end
    buffer_empty_i = 1'b0; src_valid_i = 1'b0;
    step("hs_rel");
    chk("hs_ack_low", int'(buffer_empty_ack_o), 0);

    // stalls plus a mid-fill change of buffer_sel_i
    wr_addrs.delete();
    for (int i = 0; i < 60 && wr_addrs.size() < 8; i++) begin
      src_valid_i = (i % 3 == 0);
      src_data_i  = DB'(8'h20 + i);
      if (i == 7) buffer_sel_i = 1'b1;
      step("stall");
      if (ram_wren_o) wr_addrs.push_back(int'(ram_wr_addr_o));
    end
    src_valid_i = 1'b0;
    step("stall_tail");
    chk("stall_tail_no_write", int'(ram_wren_o), 0);
    chk("stall_write_count", wr_addrs.size(), 8);
    foreach (wr_addrs[i]) chk($sformatf("stall_addr%0d", i), wr_addrs[i], 8 + i);

    // underrun: request raised after 4 accepts and held through completion
    buffer_sel_i = 1'b1; buffer_empty_i = 1'b1;
    step("ur_req");
    buffer_empty_i = 1'b0;
    step("ur_rel");
    src_valid_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      src_data_i = DB'(8'h40 + i);
      if (i == 4) buffer_empty_i = 1'b1;
      step("ur_fill");
    end
    chk("ur_flag", int'(underrun_o), 1);
    chk("ur_last_addr", int'(ram_wr_addr_o), 7);
    chk("ur_filled", int'(buffer_filled_o), 1);
    src_valid_i = 1'b0;
    step("ur_reack");
    chk("ur_reack_ack", int'(buffer_empty_ack_o), 1);
    chk("ur_sticky", int'(underrun_o), 1);
    buffer_empty_i = 1'b0; buffer_sel_i = 1'b0;
    step("ur_fill2");

    // reset mid-fill after 3 accepts
    src_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      src_data_i = DB'(8'h60 + i);
      step("rst_fill");
    end
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("rst_async_ready", int'(src_ready_o), 0);
    chk("rst_async_wren", int'(ram_wren_o), 0);
    chk("rst_async_addr", int'(ram_wr_addr_o), 0);
    chk("rst_async_under", int'(underrun_o), 0);
    compare_all("rst_async");
    #3 rst = 1'b0; src_valid_i = 1'b0;
    buffer_empty_i = 1'b1; buffer_sel_i = 1'b0;
    step("rst_req");
    buffer_empty_i = 1'b0;
    step("rst_rel");
    src_valid_i = 1'b1; src_data_i = 8'hA5;
    step("rst_first");
    chk("rst_restart_addr", int'(ram_wr_addr_o), 8);
    chk("rst_restart_data", int'(ram_wr_data_o), 8'hA5);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      buffer_empty_i = ($urandom_range(0, 5) == 0);
      buffer_sel_i   = 1'($urandom);
      src_valid_i    = ($urandom_range(0, 3) != 0);
      src_data_i     = DB'($urandom);
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
